// File: rtl/uvc_payload_sched.sv
// UVC payload scheduler: one VFB-paced payload packet per USB microframe,
// with a 2-byte UVC header (FID/EOF) in front of 24-bit pixels serialised MSB first.
module uvc_payload_sched #(
  parameter int FRAME_PIXELS = 307200,
  parameter int PKT_PIXELS   = 340,
  parameter int CNT_W        = 19
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        sof_i,
  input  logic        vfb_rdy_i,
  input  logic [23:0] vfb_data_i,
  output logic        vfb_re_o,
  output logic        vfb_vs_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        tx_last_o,
  input  logic        tx_ready_i,
  output logic        fid_o,
  output logic [15:0] frame_cnt_o
);

  localparam int LEN_W = $clog2(PKT_PIXELS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_WAIT_SOF,
    S_HDR0,
    S_HDR1,
    S_PIX,
    S_END
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] pix_cnt;
  logic [LEN_W-1:0] pkt_rem;
  logic [1:0]       byte_idx;
  logic             eof_q;
  logic             fid_q;
  logic [15:0]      frame_cnt_q;
  logic             vld_p1;
  logic [23:0]      nxt_pix_p1;
  logic [23:0]      cur_pix_p2;

  logic [CNT_W-1:0] frame_left;
  logic [LEN_W-1:0] pkt_len_c;
  logic             eof_c;
  logic             accept;
  logic             pix_last;
  logic             pix_done;
  logic [23:0]      pix_src;

  // Packet length saturates at PKT_PIXELS; the tail of the frame gets a short packet.
  function automatic logic [LEN_W-1:0] sat_pkt_len(input logic [CNT_W-1:0] left);
    if (left > CNT_W'(PKT_PIXELS)) begin
      return LEN_W'(PKT_PIXELS);
    end
    return LEN_W'(left);
  endfunction

  assign frame_left = CNT_W'(FRAME_PIXELS) - pix_cnt;
  assign pkt_len_c  = sat_pkt_len(frame_left);
  assign eof_c      = (frame_left <= CNT_W'(PKT_PIXELS));
  assign accept     = tx_valid_o & tx_ready_i;
  assign pix_last   = (pkt_rem == LEN_W'(1));
  assign pix_done   = accept && (byte_idx == 2'd2);
  // Read data lands one cycle after the strobe; bypass it when HDR1 is accepted straight away.
  assign pix_src    = vld_p1 ? vfb_data_i : nxt_pix_p1;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable_i) state_nxt = S_VSYNC;
      end
      S_VSYNC: begin
        state_nxt = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (sof_i && vfb_rdy_i) begin
          state_nxt = S_HDR0;
        end else if (!enable_i) begin
          state_nxt = S_IDLE;
        end
      end
      S_HDR0: begin
        if (accept) state_nxt = S_HDR1;
      end
      S_HDR1: begin
        if (accept) state_nxt = S_PIX;
      end
      S_PIX: begin
        if (pix_done && pix_last) state_nxt = S_END;
      end
      S_END: begin
        if (!enable_i) begin
          state_nxt = S_IDLE;
        end else if (eof_q) begin
          state_nxt = S_VSYNC;
        end else begin
          state_nxt = S_WAIT_SOF;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    vfb_re_o   = 1'b0;
    vfb_vs_o   = 1'b0;
    tx_data_o  = 8'h00;
    tx_valid_o = 1'b0;
    tx_last_o  = 1'b0;
    case (state)
      S_VSYNC: begin
        vfb_vs_o = 1'b1;
      end
      S_HDR0: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'h02;
        vfb_re_o   = tx_ready_i;
      end
      S_HDR1: begin
        tx_valid_o = 1'b1;
        tx_data_o  = {1'b1, 5'b00000, eof_q, fid_q};
      end
      S_PIX: begin
        tx_valid_o = 1'b1;
        case (byte_idx)
          2'd0:    tx_data_o = cur_pix_p2[23:16];
          2'd1:    tx_data_o = cur_pix_p2[15:8];
          default: tx_data_o = cur_pix_p2[7:0];
        endcase
        tx_last_o = (byte_idx == 2'd2) && pix_last;
        vfb_re_o  = tx_ready_i && (byte_idx == 2'd0) && (pkt_rem > LEN_W'(1));
      end
      default: begin
        tx_valid_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt     <= '0;
      pkt_rem     <= '0;
      byte_idx    <= '0;
      eof_q       <= 1'b0;
      fid_q       <= 1'b0;
      frame_cnt_q <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= vfb_re_o;
      case (state)
        S_VSYNC: begin
          pix_cnt <= '0;
        end
        S_WAIT_SOF: begin
          if (sof_i && vfb_rdy_i) begin
            pkt_rem  <= pkt_len_c;
            eof_q    <= eof_c;
            byte_idx <= '0;
          end
        end
        S_PIX: begin
          if (accept) begin
            if (byte_idx == 2'd2) begin
              byte_idx <= '0;
              pix_cnt  <= pix_cnt + CNT_W'(1);
              pkt_rem  <= pkt_rem - LEN_W'(1);
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        S_END: begin
          // A frame cut short by disable still flips FID so the host drops it.
          if (eof_q || !enable_i) fid_q <= ~fid_q;
          if (eof_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            pix_cnt     <= '0;
          end
        end
        default: begin
          pix_cnt <= pix_cnt;
        end
      endcase
    end
  end

  // p1: pixel captured the cycle after the read strobe; p2: pixel being serialised.
  always_ff @(posedge clk_i) begin
    if (vld_p1) nxt_pix_p1 <= vfb_data_i;
    if ((state == S_HDR1 && accept) || (state == S_PIX && pix_done)) cur_pix_p2 <= pix_src;
  end

  assign fid_o       = fid_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_uvc_payload_sched.sv
// Directed bench for uvc_payload_sched with an 8-pixel frame and 3-pixel packets.
module tb_uvc_payload_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  logic        sof_i = 1'b0;
  logic        vfb_rdy_i = 1'b1;
  logic [23:0] vfb_data_i = 24'h0;
  logic        tx_ready_i = 1'b1;
  logic        vfb_re_o;
  logic        vfb_vs_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_last_o;
  logic        fid_o;
  logic [15:0] frame_cnt_o;

  uvc_payload_sched #(
    .FRAME_PIXELS(8),
    .PKT_PIXELS  (3),
    .CNT_W       (4)
  ) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .sof_i      (sof_i),
    .vfb_rdy_i  (vfb_rdy_i),
    .vfb_data_i (vfb_data_i),
    .vfb_re_o   (vfb_re_o),
    .vfb_vs_o   (vfb_vs_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_last_o  (tx_last_o),
    .tx_ready_i (tx_ready_i),
    .fid_o      (fid_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sof_en = 1'b0;
  bit rand_rdy = 1'b0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int re_cnt = 0, vs_cnt = 0, sof_cnt = 0, valid_cnt = 0;
  int mcyc = 0, sof_cyc = 0, first_vld_cyc = -1;
  bit stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int rd_idx = 0;

  function automatic logic [23:0] pix_of(input int i);
    logic [7:0] k;
    k = 8'(i);
    if (i == 0) return 24'hA1B2C3;
    if (i == 1) return 24'hD4E5F6;
    return {8'h10 + k, 8'h20 + k, 8'h30 + k};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sof_i = sof_en && (cyc % 40 == 0);
    if (rand_rdy) tx_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic add_pkt(input logic [7:0] h1, input int first, input int n);
    logic [23:0] p;
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b0, h1});
    for (int i = 0; i < n; i++) begin
      p = pix_of(first + i);
      exp_q.push_back({1'b0, p[23:16]});
      exp_q.push_back({1'b0, p[15:8]});
      exp_q.push_back({(i == n - 1), p[7:0]});
    end
  endtask

  task automatic cmp_stream(input string tag, input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size())
        chk($sformatf("%s[%0d]", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
      else
        chk($sformatf("%s[%0d]_missing", tag, i), 32'(base + i), 32'(got_q.size()));
    end
  endtask

  // VFB model: pixel index restarts on each frame-start pulse.
  initial begin
    forever begin
      @(posedge clk);
      if (vfb_vs_o) begin
        rd_idx = 0;
      end else if (vfb_re_o) begin
        vfb_data_i <= pix_of(rd_idx);
        rd_idx++;
      end
    end
  end

  // Monitor: collects accepted bytes and event counts, checks AXI-style hold.
  initial begin
    forever begin
      @(negedge clk);
      mcyc++;
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          assert (tx_valid_o === 1'b1 && tx_data_o === prev_data) else begin
            failures++;
            $error("FAIL hold observed=%0b/%02h expected=1/%02h", tx_valid_o, tx_data_o, prev_data);
          end
        end
        if (tx_valid_o && tx_ready_i) got_q.push_back({tx_last_o, tx_data_o});
        if (tx_valid_o) begin
          valid_cnt++;
          if (first_vld_cyc < 0) first_vld_cyc = mcyc;
        end
        if (vfb_re_o) re_cnt++;
        if (vfb_vs_o) vs_cnt++;
        if (sof_i) begin
          sof_cnt++;
          sof_cyc = mcyc;
        end
        stall_prev = tx_valid_o && !tx_ready_i;
        prev_data  = tx_data_o;
      end
    end
  end

  initial begin
    int n;
    int base;
    int gsz;

    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", 32'(tx_valid_o), 0);
    chk("rst_data", 32'(tx_data_o), 0);
    chk("rst_last", 32'(tx_last_o), 0);
    chk("rst_re", 32'(vfb_re_o), 0);
    chk("rst_vs", 32'(vfb_vs_o), 0);
    chk("rst_fid", 32'(fid_o), 0);
    chk("rst_frame_cnt", 32'(frame_cnt_o), 0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("idle_quiet", 32'(valid_cnt + vs_cnt + re_cnt), 0);

    // Frame 1, no back-pressure
    sof_en = 1'b1;
    enable_i = 1'b1;
    n = 0;
    while (frame_cnt_o !== 16'd1 && n < 400) begin step(); n++; end
    chk("frame1_timeout", 32'(n < 400), 1);
    step();
    add_pkt(8'h80, 0, 3);
    add_pkt(8'h80, 3, 3);
    add_pkt(8'h82, 6, 2);
    chk("frame1_bytes", 32'(got_q.size()), 30);
    cmp_stream("frame1", 0);
    chk("frame1_vs", 32'(vs_cnt), 2);
    chk("frame1_re", 32'(re_cnt), 8);
    chk("frame1_fid", 32'(fid_o), 1);
    chk("frame1_cnt", 32'(frame_cnt_o), 1);
    got_q.delete();
    exp_q.delete();
    re_cnt = 0;

    // Frame 2, random back-pressure
    rand_rdy = 1'b1;
    n = 0;
    while (frame_cnt_o !== 16'd2 && n < 1500) begin step(); n++; end
    chk("frame2_timeout", 32'(n < 1500), 1);
    vfb_rdy_i = 1'b0;
    rand_rdy = 1'b0;
    tx_ready_i = 1'b1;
    add_pkt(8'h81, 0, 3);
    add_pkt(8'h81, 3, 3);
    add_pkt(8'h83, 6, 2);
    chk("frame2_bytes", 32'(got_q.size()), 30);
    cmp_stream("frame2", 0);
    chk("frame2_re", 32'(re_cnt), 8);
    chk("frame2_fid", 32'(fid_o), 0);
    chk("frame2_cnt", 32'(frame_cnt_o), 2);
    got_q.delete();
    exp_q.delete();
    re_cnt = 0;
    valid_cnt = 0;

    // Two microframes with the VFB not ready
    base = sof_cnt;
    n = 0;
    while (sof_cnt < base + 2 && n < 150) begin step(); n++; end
    chk("nordy_timeout", 32'(n < 150), 1);
    chk("nordy_valid", 32'(valid_cnt), 0);
    chk("nordy_re", 32'(re_cnt), 0);
    vfb_rdy_i = 1'b1;
    first_vld_cyc = -1;
    n = 0;
    while (got_q.size() < 11 && n < 200) begin step(); n++; end
    chk("rdy_pkt_timeout", 32'(n < 200), 1);
    chk("rdy_sof_index", 32'(sof_cnt - base), 3);
    chk("rdy_start_lat", 32'(first_vld_cyc - sof_cyc), 1);
    add_pkt(8'h80, 0, 3);
    cmp_stream("f3pkt1", 0);
    exp_q.delete();

    // Enable dropped during packet 2
    n = 0;
    while (tx_valid_o !== 1'b1 && n < 100) begin step(); n++; end
    chk("pkt2_start_timeout", 32'(n < 100), 1);
    enable_i = 1'b0;
    n = 0;
    while (got_q.size() < 22 && n < 100) begin step(); n++; end
    chk("pkt2_timeout", 32'(n < 100), 1);
    repeat (2) step();
    add_pkt(8'h80, 3, 3);
    cmp_stream("f3pkt2", 11);
    exp_q.delete();
    chk("dis_fid", 32'(fid_o), 1);
    chk("dis_cnt", 32'(frame_cnt_o), 2);
    valid_cnt = 0;
    re_cnt = 0;
    repeat (90) step();
    chk("dis_idle_bytes", 32'(got_q.size()), 22);
    chk("dis_idle_valid", 32'(valid_cnt + re_cnt), 0);
    vs_cnt = 0;
    enable_i = 1'b1;
    repeat (3) step();
    chk("reen_vs", 32'(vs_cnt), 1);
    n = 0;
    while (got_q.size() < 24 && n < 100) begin step(); n++; end
    chk("reen_timeout", 32'(n < 100), 1);
    chk("reen_hdr0", 32'(got_q[22]), 32'h002);
    chk("reen_hdr1", 32'(got_q[23]), 32'h081);

    // Asynchronous reset in the middle of the pixel phase
    n = 0;
    while (got_q.size() < 25 && n < 20) begin step(); n++; end
    chk("pix_timeout", 32'(n < 20), 1);
    chk("pre_rst_valid", 32'(tx_valid_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_valid_o), 0);
    chk("arst_data", 32'(tx_data_o), 0);
    chk("arst_last", 32'(tx_last_o), 0);
    chk("arst_re", 32'(vfb_re_o), 0);
    chk("arst_vs", 32'(vfb_vs_o), 0);
    chk("arst_fid", 32'(fid_o), 0);
    chk("arst_cnt", 32'(frame_cnt_o), 0);
    enable_i = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    valid_cnt = 0;
    re_cnt = 0;
    vs_cnt = 0;
    repeat (90) step();
    chk("post_rst_quiet", 32'(valid_cnt + re_cnt + vs_cnt), 0);
    gsz = got_q.size();
    enable_i = 1'b1;
    n = 0;
    while (got_q.size() < gsz + 2 && n < 150) begin step(); n++; end
    chk("post_rst_timeout", 32'(n < 150), 1);
    chk("post_rst_vs", 32'(vs_cnt), 1);
    if (got_q.size() >= gsz + 2) begin
      chk("post_rst_hdr0", 32'(got_q[gsz]), 32'h002);
      chk("post_rst_hdr1", 32'(got_q[gsz + 1]), 32'h080);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uvc_payload_sched.md
Name: uvc_payload_sched

Overview:
- Per-microframe scheduler between the video frame buffer (VFB) and the USB UVC bulk/iso IN path.
- Paces VFB reads: one payload packet per USB SOF/microframe tick.
- Prepends the 2-byte UVC payload header (FID/EOF) and serialises 24-bit pixels to a byte stream.
- Sequences frame start (vfb_vs_o), FID toggling and the frame counter.

Parameters:
- FRAME_PIXELS, 307200: pixels per video frame.
- PKT_PIXELS, 340: maximum pixels per payload packet (1020 data bytes plus 2 header bytes).
- CNT_W, 19: pixel counter width; must satisfy 2^CNT_W > FRAME_PIXELS.

Ports:
- clk_i  in  1  USB clock (60 MHz ULPI domain).
- rst_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  streaming committed by host (level).
- sof_i  in  1  one-cycle pulse per USB microframe.
- vfb_rdy_i  in  1  VFB holds at least one full packet of pixels.
- vfb_data_i  in  24  pixel; valid the cycle after vfb_re_o.
- vfb_re_o  out  1  pixel read strobe.
- vfb_vs_o  out  1  one-cycle frame-start pulse to VFB.
- tx_data_o  out  8  payload byte.
- tx_valid_o  out  1  byte valid.
- tx_last_o  out  1  last byte of packet.
- tx_ready_i  in  1  byte accepted when high together with tx_valid_o.
- fid_o  out  1  current frame ID bit.
- frame_cnt_o  out  16  completed frames, wraps at 0xFFFF to 0.

Behaviour:
- Reset values: all outputs 0; state IDLE; pixel counter 0.
- States and transitions:
  - IDLE: on enable_i=1, go to VSYNC.
  - VSYNC: vfb_vs_o=1 for exactly this cycle; pixel counter cleared; go to WAIT_SOF.
  - WAIT_SOF: on sof_i=1 with vfb_rdy_i=1, latch pkt_len = min(PKT_PIXELS, FRAME_PIXELS - pix_cnt) and eof = (pix_cnt + pkt_len == FRAME_PIXELS); go to HDR0. With enable_i=0, go to IDLE. sof_i with vfb_rdy_i=0 is skipped; no packet is sent for that microframe.
  - HDR0: tx_data_o=0x02 (header length). On accept, assert vfb_re_o for one cycle; go to HDR1.
  - HDR1: tx_data_o = {1'b1, 5'b0, eof, fid}. On accept, cur_pix <= nxt_pix; go to PIX.
  - PIX: bytes cur_pix[23:16], [15:8], [7:0] in that order.
    - On accept of byte 0: if pixels remaining in the packet after the current one > 0, assert vfb_re_o for one cycle. The next cycle captures vfb_data_i into nxt_pix.
    - On accept of byte 2: pix_cnt++; cur_pix <= nxt_pix.
    - tx_last_o=1 on byte 2 of the final pixel of the packet; that accept goes to END.
  - END:
    - If eof: fid toggles, frame_cnt_o++, pix_cnt=0; then go to VSYNC if enable_i=1, else IDLE.
    - Else: go to WAIT_SOF.
- Throughput: sustains 1 byte/cycle with tx_ready_i tied high. A packet takes 2 + 3*pkt_len accept cycles.
- tx_valid_o is high in HDR0, HDR1 and PIX. It stays high and tx_data_o stays stable until accepted (AXI-style hold).
- vfb_re_o is never asserted outside HDR0/PIX. Total vfb_re_o pulses per packet = pkt_len exactly.
- enable_i deasserted mid-packet: the packet completes normally. In END the block goes to IDLE regardless of eof.
  - If !eof, fid still toggles so the host discards the partial frame; frame_cnt_o is unchanged.
  - Re-enable restarts with a vfb_vs_o pulse and pix_cnt=0.
- sof_i while not in WAIT_SOF is ignored (no queuing).
- sof_i in the same cycle as the END→WAIT_SOF transition is also ignored.
- The VFB must not underflow after vfb_rdy_i is sampled high; no underflow check is performed.
- Reset asserted mid-packet: immediate return to reset values. Any partial packet is dropped; the downstream packetiser flushes on reset.

Test Plan (bench parameters FRAME_PIXELS=8, PKT_PIXELS=3):
- Reset, enable_i=1, vfb_rdy_i=1, tx_ready_i=1, sof_i every 40 cycles -> one vfb_vs_o pulse. Packets of 3/3/2 pixels: 11, 11, 8 bytes. Headers 0x02,0x80 / 0x02,0x80 / 0x02,0x82. After packet 3: fid_o=1, frame_cnt_o=1, new vfb_vs_o pulse.
- Pixel data 0xA1B2C3, 0xD4E5F6 -> byte stream A1,B2,C3,D4,E5,F6 after the header. tx_last_o high only on the final byte.
- tx_ready_i random 50% -> tx_data_o/tx_valid_o held while stalled. Byte sequence identical to the unstalled run. vfb_re_o count = 8 per frame.
- vfb_rdy_i=0 for two sof_i pulses -> no tx_valid_o, no vfb_re_o. First sof_i with vfb_rdy_i=1 starts the next packet.
- enable_i dropped during packet 2 -> packet 2 completes (11 bytes, EOF=0), fid_o toggles, frame_cnt_o unchanged, state IDLE. Re-enable -> vfb_vs_o pulse, first header byte1 = 0x81.
- rst_n low mid-PIX -> all outputs 0 immediately. After release, no output activity until enable_i and sof_i.
